// File: rtl/roberto_pkg.sv
// Shared definitions for the roberto host-side command transmitter:
// ASCII mapping, frame geometry and sequencer state codes. The state codes
// are shown on a hex 7-segment display, so their numeric values are fixed.
package roberto_pkg;

   // Character mapping: position code 0..7 becomes ASCII '0'..'7'
   localparam logic [6:0] ASCII_ZERO = 7'h30;

   // Number of servo characters per command
   localparam int N_SERVOS = 3;

   // 7E2 frame: start + 7 data + parity + 2 stop
   localparam int BITS_FRAME = 11;

   // Sequencer state codes (also the db_estado debug encoding)
   typedef logic [3:0] estado_t;
   localparam estado_t ST_INICIAL   = 4'd0;
   localparam estado_t ST_CARREGA   = 4'd1;
   localparam estado_t ST_TRANSMITE = 4'd2;
   localparam estado_t ST_PROXIMO   = 4'd3;
   localparam estado_t ST_FINAL     = 4'd4;

   // Convert a 3-bit position code into its ASCII digit
   function automatic logic [6:0] pos_to_ascii(input logic [2:0] pos);
      return ASCII_ZERO + {4'b0000, pos};
   endfunction

   // Even parity bit: makes the total count of ones (data + parity) even
   function automatic logic parity_even(input logic [6:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/tx_serial_7E2.sv
// Single-character 7E2 asynchronous serial transmitter.
// Handshake: partida is a one-cycle request, accepted only while idle; dado
// must be valid in that cycle. pronto_char is a one-cycle notice raised one
// clock before the second stop bit ends, so a sequencer that spends one
// cycle reacting to it and one cycle re-arming a registered partida leaves
// exactly two idle cycles on the line between characters.
module tx_serial_7E2
   import roberto_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [6:0] dado,
   output logic       saida_serial,
   output logic       pronto_char
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TICK_WARN = TW'(CLKS_PER_BIT - 2);
   localparam logic [3:0]    BIT_LAST  = 4'(BITS_FRAME - 1);

   logic [BITS_FRAME-1:0] shift_q, shift_d;
   logic                  busy_q, busy_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [3:0]            bit_q, bit_d;

   // Next-state logic: load a frame on request, then shift one bit per baud period
   always_comb begin
      shift_d = shift_q;
      busy_d  = busy_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      if (!busy_q) begin
         if (partida) begin
            // LSB leaves first: start(0), data[0..6], parity, stop, stop
            shift_d = {2'b11, parity_even(dado), dado, 1'b0};
            busy_d  = 1'b1;
            tick_d  = '0;
            bit_d   = '0;
         end
      end else if (tick_q == TICK_LAST) begin
         tick_d  = '0;
         shift_d = {1'b1, shift_q[BITS_FRAME-1:1]};
         if (bit_q == BIT_LAST) begin
            busy_d = 1'b0;
         end else begin
            bit_d = bit_q + 4'd1;
         end
      end else begin
         tick_d = tick_q + TW'(1);
      end
   end

   // State registers; reset returns the line to idle immediately
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_q <= '1;
         busy_q  <= 1'b0;
         tick_q  <= '0;
         bit_q   <= '0;
      end else begin
         shift_q <= shift_d;
         busy_q  <= busy_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
      end
   end

   // Line output and early end-of-character notice
   always_comb begin
      saida_serial = busy_q ? shift_q[0] : 1'b1;
      pronto_char  = busy_q && (bit_q == BIT_LAST) && (tick_q == TICK_WARN);
   end

endmodule

// File: rtl/roberto_comando_tx.sv
// Host-side command transmitter for the roberto robot: on enviar it latches
// three servo position codes and sends them as three ASCII digits (servo 1
// first) in 7E2 frames, then pulses pronto.
// Handshake: enviar is a one-cycle request honoured only in ST_INICIAL;
// ocupado stays high from acceptance until the cycle pronto is high, and any
// request seen while ocupado is high is dropped (no queuing).
module roberto_comando_tx
   import roberto_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enviar,
   input  logic [2:0] pos1,
   input  logic [2:0] pos2,
   input  logic [2:0] pos3,
   output logic       saida_serial,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   localparam logic [1:0] CNT_LAST = 2'(N_SERVOS - 1);

   estado_t    state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [2:0] pos1_q, pos1_d;
   logic [2:0] pos2_q, pos2_d;
   logic [2:0] pos3_q, pos3_d;
   logic       partida_q, partida_d;

   logic [2:0] pos_sel;
   logic [6:0] dado;
   logic       pronto_char;

   // Sequencer: latch, load each character, wait for it, advance, finish
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pos1_d    = pos1_q;
      pos2_d    = pos2_q;
      pos3_d    = pos3_q;
      partida_d = 1'b0;
      case (state_q)
         ST_INICIAL: begin
            if (enviar) begin
               state_d = ST_CARREGA;
               pos1_d  = pos1;
               pos2_d  = pos2;
               pos3_d  = pos3;
            end
         end
         ST_CARREGA: begin
            partida_d = 1'b1;
            state_d   = ST_TRANSMITE;
         end
         ST_TRANSMITE: begin
            if (pronto_char) begin
               state_d = ST_PROXIMO;
            end
         end
         ST_PROXIMO: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FINAL;
            end else begin
               cnt_d   = cnt_q + 2'd1;
               state_d = ST_CARREGA;
            end
         end
         ST_FINAL: begin
            cnt_d   = '0;
            state_d = ST_INICIAL;
         end
         default: begin
            // Unused codes recover to idle
            cnt_d   = '0;
            state_d = ST_INICIAL;
         end
      endcase
   end

   // Sequencer, counter, position latches and registered start request
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_INICIAL;
         cnt_q     <= '0;
         pos1_q    <= '0;
         pos2_q    <= '0;
         pos3_q    <= '0;
         partida_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pos1_q    <= pos1_d;
         pos2_q    <= pos2_d;
         pos3_q    <= pos3_d;
         partida_q <= partida_d;
      end
   end

   // Character mux: the counter picks which latched position goes out
   always_comb begin
      case (cnt_q)
         2'd0:    pos_sel = pos1_q;
         2'd1:    pos_sel = pos2_q;
         default: pos_sel = pos3_q;
      endcase
      dado = pos_to_ascii(pos_sel);
   end

   // Status outputs derived straight from the state register so reset acts at once
   always_comb begin
      ocupado   = (state_q != ST_INICIAL);
      pronto    = (state_q == ST_FINAL);
      db_estado = state_q;
   end

   tx_serial_7E2 #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clock       (clock),
      .reset       (reset),
      .partida     (partida_q),
      .dado        (dado),
      .saida_serial(saida_serial),
      .pronto_char (pronto_char)
   );

endmodule
